// File: rtl/m_to_n_async_fifo.sv
// Single-clock FIFO shared by M writer lanes and N reader lanes over one circular buffer.
// Lanes are granted in ascending index order against pre-edge space/occupancy; excess requests drop.
module m_to_n_async_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 5,
  parameter int PFULL_TH  = 2,
  parameter int PEMPTY_TH = 8,
  parameter int M_WRITERS = 2,
  parameter int N_READERS = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [M_WRITERS-1:0]         i_wr_en,
  input  logic [M_WRITERS*WIDTH-1:0]   i_wr_data,
  output logic [M_WRITERS-1:0]         o_wr_ed,
  output logic                         o_wr_full,
  output logic                         o_wr_afull,
  output logic                         o_wr_pfull,
  output logic [DEPTH:0]               o_wr_remain,
  input  logic [N_READERS-1:0]         i_rd_en,
  output logic [N_READERS*WIDTH-1:0]   o_rd_data,
  output logic [N_READERS-1:0]         o_rd_valid,
  output logic                         o_rd_empty,
  output logic                         o_rd_aempty,
  output logic                         o_rd_pempty,
  output logic [DEPTH:0]               o_rd_depth
);

  localparam int             CAP     = 1 << DEPTH;
  localparam logic [DEPTH:0] CAP_C   = (DEPTH+1)'(CAP);
  localparam logic [DEPTH:0] CNT_ONE = (DEPTH+1)'(1);

  logic [WIDTH-1:0] mem [CAP];

  logic [DEPTH-1:0]         wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]           count_q, count_d;
  logic [DEPTH:0]           free_space, wr_cnt, rd_cnt;
  logic [M_WRITERS-1:0]     wr_gnt, wr_ed_q, wr_ed_d;
  logic [N_READERS-1:0]     rd_gnt, rd_valid_q, rd_valid_d;
  logic [N_READERS*WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DEPTH-1:0]         wr_slot [M_WRITERS];
  logic [DEPTH-1:0]         rd_slot [N_READERS];

  assign free_space = CAP_C - count_q;

  // Grant g lands at wr_ptr+g; the running grant count doubles as the slot offset.
  always_comb begin
    wr_gnt = '0;
    wr_cnt = '0;
    for (int k = 0; k < M_WRITERS; k++) begin
      wr_slot[k] = wr_ptr_q + wr_cnt[DEPTH-1:0];
      if (i_wr_en[k] && (wr_cnt < free_space)) begin
        wr_gnt[k] = 1'b1;
        wr_cnt    = wr_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    rd_gnt    = '0;
    rd_cnt    = '0;
    rd_data_d = rd_data_q;
    for (int j = 0; j < N_READERS; j++) begin
      rd_slot[j] = rd_ptr_q + rd_cnt[DEPTH-1:0];
      if (i_rd_en[j] && (rd_cnt < count_q)) begin
        rd_gnt[j] = 1'b1;
        rd_cnt    = rd_cnt + CNT_ONE;
        rd_data_d[j*WIDTH +: WIDTH] = mem[rd_slot[j]];
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + wr_cnt[DEPTH-1:0];
    rd_ptr_d   = rd_ptr_q + rd_cnt[DEPTH-1:0];
    count_d    = count_q + wr_cnt - rd_cnt;
    wr_ed_d    = wr_gnt;
    rd_valid_d = rd_gnt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ed_q    <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ed_q    <= wr_ed_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is left unreset; writes are masked while reset is asserted.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < M_WRITERS; k++) begin
      if (i_rstn && wr_gnt[k]) begin
        mem[wr_slot[k]] <= i_wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign o_wr_ed     = wr_ed_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_wr_remain = free_space;
  assign o_rd_depth  = count_q;
  assign o_wr_full   = (count_q == CAP_C);
  assign o_wr_afull  = (int'(count_q) >= CAP - 1);
  assign o_wr_pfull  = (int'(free_space) <= PFULL_TH);
  assign o_rd_empty  = (count_q == '0);
  assign o_rd_aempty = (int'(count_q) <= 1);
  assign o_rd_pempty = (int'(count_q) <= PEMPTY_TH);

endmodule

// File: tb/tb_m_to_n_async_fifo.sv
// Directed bench for m_to_n_async_fifo (2 writers, 1 reader, 32 entries).
// Each scenario task drives inputs and checks outputs #1 after the rising edge.
module tb_m_to_n_async_fifo;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  wr_en;
  logic [15:0] wr_data;
  logic [1:0]  wr_ed;
  logic        wr_full, wr_afull, wr_pfull;
  logic [5:0]  wr_remain;
  logic [0:0]  rd_en;
  logic [7:0]  rd_data;
  logic [0:0]  rd_valid;
  logic        rd_empty, rd_aempty, rd_pempty;
  logic [5:0]  rd_depth;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_to_n_async_fifo #(
    .WIDTH(8), .DEPTH(5), .PFULL_TH(2), .PEMPTY_TH(8), .M_WRITERS(2), .N_READERS(1)
  ) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_wr_ed(wr_ed), .o_wr_full(wr_full), .o_wr_afull(wr_afull),
    .o_wr_pfull(wr_pfull), .o_wr_remain(wr_remain),
    .i_rd_en(rd_en), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_rd_empty(rd_empty), .o_rd_aempty(rd_aempty), .o_rd_pempty(rd_pempty),
    .o_rd_depth(rd_depth)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_en = 2'b11; wr_data = 16'hFFEE; rd_en = 1'b1;
    repeat (3) tick();
    checks++;
    if ({rd_empty, rd_aempty, rd_pempty, wr_full, wr_afull, wr_pfull} !== 6'b111000) begin
      errors++; $display("FAIL reset_flags: got %b expected 111000",
        {rd_empty, rd_aempty, rd_pempty, wr_full, wr_afull, wr_pfull});
    end
    checks++;
    if ({wr_ed, rd_valid, rd_data} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs: got ed=%b v=%b d=%h expected 0", wr_ed, rd_valid, rd_data);
    end
    rstn = 1'b1; wr_en = 2'b00; rd_en = 1'b0;
    tick();
    checks++;
    if (rd_depth !== 6'd0 || wr_remain !== 6'd32) begin
      errors++; $display("FAIL reset_release: got depth=%0d remain=%0d expected 0/32", rd_depth, wr_remain);
    end
    $display("test_reset done: depth=%0d remain=%0d", rd_depth, wr_remain);
  endtask

  task automatic test_fill();
    wr_en = 2'b11; wr_data = {8'h31, 8'h01}; rd_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (wr_ed !== 2'b11 || rd_depth !== 6'(2*(i+1))) begin
        errors++; $display("FAIL fill_%0d: got ed=%b depth=%0d expected 11/%0d", i, wr_ed, rd_depth, 2*(i+1));
      end
      checks++;
      if (wr_pfull !== (2*(i+1) >= 30)) begin
        errors++; $display("FAIL fill_pfull_%0d: got %b expected %b", i, wr_pfull, (2*(i+1) >= 30));
      end
      $display("fill cycle %0d: ed=%b depth=%0d pfull=%b", i, wr_ed, rd_depth, wr_pfull);
    end
    checks++;
    if ({wr_full, wr_afull, wr_pfull, rd_empty} !== 4'b1110 || wr_remain !== 6'd0) begin
      errors++; $display("FAIL fill_final: got f/af/pf/e=%b remain=%0d expected 1110/0",
        {wr_full, wr_afull, wr_pfull, rd_empty}, wr_remain);
    end
  endtask

  task automatic test_partial_accept();
    wr_en = 2'b00; rd_en = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h01 || rd_depth !== 6'd31 || wr_ed !== 2'b00) begin
      errors++; $display("FAIL pop_one: got v=%b d=%h depth=%0d ed=%b expected 1/01/31/00",
        rd_valid, rd_data, rd_depth, wr_ed);
    end
    wr_en = 2'b11; wr_data = {8'hB1, 8'hA0}; rd_en = 1'b0;
    tick();
    checks++;
    if (wr_ed !== 2'b01 || wr_full !== 1'b1 || rd_depth !== 6'd32) begin
      errors++; $display("FAIL partial_accept: got ed=%b full=%b depth=%0d expected 01/1/32",
        wr_ed, wr_full, rd_depth);
    end
    $display("partial accept: ed=%b depth=%0d", wr_ed, rd_depth);
  endtask

  task automatic test_concurrent_full();
    wr_en = 2'b11; wr_data = {8'hD3, 8'hC2}; rd_en = 1'b1;
    tick();
    checks++;
    if (wr_ed !== 2'b00 || rd_valid !== 1'b1 || rd_data !== 8'h31 || rd_depth !== 6'd31) begin
      errors++; $display("FAIL concurrent_full: got ed=%b v=%b d=%h depth=%0d expected 00/1/31/31",
        wr_ed, rd_valid, rd_data, rd_depth);
    end
    $display("concurrent at full: ed=%b rd=%h depth=%0d", wr_ed, rd_data, rd_depth);
  endtask

  task automatic test_drain_order();
    logic [7:0] exp;
    wr_en = 2'b00; rd_en = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick();
      exp = (i == 30) ? 8'hA0 : ((i % 2 == 0) ? 8'h01 : 8'h31);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp || rd_depth !== 6'(30 - i)) begin
        errors++; $display("FAIL drain_%0d: got v=%b d=%h depth=%0d expected 1/%h/%0d",
          i, rd_valid, rd_data, rd_depth, exp, 30 - i);
      end
      checks++;
      if (rd_pempty !== ((30 - i) <= 8) || rd_aempty !== ((30 - i) <= 1)) begin
        errors++; $display("FAIL drain_flags_%0d: got pe=%b ae=%b expected %b/%b",
          i, rd_pempty, rd_aempty, ((30 - i) <= 8), ((30 - i) <= 1));
      end
      $display("drain %0d: data=%h depth=%0d", i, rd_data, rd_depth);
    end
  endtask

  task automatic test_underflow();
    wr_en = 2'b00; rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b0 || rd_depth !== 6'd0 || rd_data !== 8'hA0 || rd_empty !== 1'b1) begin
        errors++; $display("FAIL underflow_%0d: got v=%b depth=%0d d=%h empty=%b expected 0/0/a0/1",
          i, rd_valid, rd_depth, rd_data, rd_empty);
      end
    end
    $display("underflow: v=%b depth=%0d", rd_valid, rd_depth);
  endtask

  task automatic test_wrap_order();
    logic [7:0] tag;
    rd_en = 1'b0; wr_en = 2'b11;
    for (int c = 0; c < 16; c++) begin
      tag = 8'h40 + 8'(2*c);
      wr_data = {tag + 8'h01, tag};
      tick();
      checks++;
      if (wr_ed !== 2'b11) begin
        errors++; $display("FAIL wrap_write_%0d: got ed=%b expected 11", c, wr_ed);
      end
    end
    wr_en = 2'b00; rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      tag = 8'h40 + 8'(i);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== tag) begin
        errors++; $display("FAIL wrap_read_%0d: got v=%b d=%h expected 1/%h", i, rd_valid, rd_data, tag);
      end
      $display("wrap read %0d: data=%h", i, rd_data);
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_empty !== 1'b1) begin
      errors++; $display("FAIL wrap_idle: got v=%b empty=%b expected 0/1", rd_valid, rd_empty);
    end
  endtask

  task automatic test_midreset();
    wr_en = 2'b11; wr_data = {8'h77, 8'h66}; rd_en = 1'b0;
    repeat (2) tick();
    rstn = 1'b0; rd_en = 1'b1;
    tick();
    checks++;
    if (rd_depth !== 6'd0 || wr_ed !== 2'b00 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      errors++; $display("FAIL midreset: got depth=%0d ed=%b v=%b d=%h expected 0/00/0/00",
        rd_depth, wr_ed, rd_valid, rd_data);
    end
    rstn = 1'b1; wr_en = 2'b00;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_depth !== 6'd0 || wr_remain !== 6'd32) begin
      errors++; $display("FAIL midreset_after: got v=%b depth=%0d remain=%0d expected 0/0/32",
        rd_valid, rd_depth, wr_remain);
    end
    $display("midreset: depth=%0d", rd_depth);
  endtask

  initial begin
    rstn = 1'b0; wr_en = 2'b00; wr_data = 16'h0; rd_en = 1'b0;
    test_reset();
    test_fill();
    test_partial_accept();
    test_concurrent_full();
    test_drain_order();
    test_underflow();
    test_wrap_order();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
